// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, video and RAM-side signals around the memory port arbiter.
// slave = arbiter view; master = requesters plus RAM macro view.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 17
);
  localparam int unsigned CPU_AW = 24;

  logic              cpu_req;
  logic              cpu_we;
  logic [CPU_AW-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_stall;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    input  vid_req, vid_addr,
    output vid_stall, vid_rvalid, vid_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    output vid_req, vid_addr,
    input  vid_stall, vid_rvalid, vid_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU memory stage and the video engine:
// CPU priority with a starvation guard, registered RAM command, tagged read return.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DEPTH      = 90000,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned     CPU_AW  = 24;
  localparam int unsigned     CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             force_vid;
  logic             grant_cpu;
  logic             grant_vid;
  logic             cpu_oor;
  logic             vid_oor;

  // Read-return tag stage aligned with the cycle the RAM is enabled
  logic             p1_valid;
  logic             p1_vid;
  logic             p1_oor;

  // Arbitration, stalls and next starvation count
  always_comb begin
    force_vid      = 1'b0;
    grant_cpu      = 1'b0;
    grant_vid      = 1'b0;
    cpu_oor        = 1'b0;
    vid_oor        = 1'b0;
    bus.cpu_stall  = 1'b0;
    bus.vid_stall  = 1'b0;
    starve_cnt_nxt = starve_cnt;

    cpu_oor   = bus.cpu_addr >= CPU_AW'(DEPTH);
    vid_oor   = bus.vid_addr >= ADDR_W'(DEPTH);
    force_vid = bus.vid_req && (starve_cnt == CNT_MAX);

    if (!rst) begin
      grant_vid     = bus.vid_req && (force_vid || !bus.cpu_req);
      grant_cpu     = bus.cpu_req && !force_vid;
      bus.cpu_stall = bus.cpu_req && !grant_cpu;
      bus.vid_stall = bus.vid_req && !grant_vid;

      if (!bus.vid_req || grant_vid) begin
        starve_cnt_nxt = '0;
      end else if (starve_cnt < CNT_MAX) begin
        starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
    end
  end

  // Command issue, error pulse and two-stage read return
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt     <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.cpu_err    <= 1'b0;
      p1_valid       <= 1'b0;
      p1_vid         <= 1'b0;
      p1_oor         <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.vid_rvalid <= 1'b0;
      bus.vid_rdata  <= '0;
    end else begin
      starve_cnt  <= starve_cnt_nxt;
      bus.mem_en  <= (grant_cpu && !cpu_oor) || (grant_vid && !vid_oor);
      bus.mem_we  <= grant_cpu && !cpu_oor && bus.cpu_we;
      bus.cpu_err <= grant_cpu && cpu_oor;

      if (grant_cpu) begin
        bus.mem_addr  <= bus.cpu_addr[ADDR_W-1:0];
        bus.mem_wdata <= bus.cpu_wdata;
      end else if (grant_vid) begin
        bus.mem_addr  <= bus.vid_addr;
      end

      // Stores carry no tag, so they never produce an rvalid
      p1_valid <= (grant_cpu && !bus.cpu_we) || grant_vid;
      p1_vid   <= grant_vid;
      p1_oor   <= grant_cpu ? cpu_oor : vid_oor;

      bus.cpu_rvalid <= p1_valid && !p1_vid;
      bus.vid_rvalid <= p1_valid && p1_vid;
      if (p1_valid && !p1_vid) begin
        bus.cpu_rdata <= p1_oor ? DATA_W'(0) : bus.mem_rdata;
      end
      if (p1_valid && p1_vid) begin
        bus.vid_rdata <= p1_oor ? DATA_W'(0) : bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level
// model: command order against a golden memory, latency expressed as cycle offsets.
module tb_mem_port_arbiter;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DEPTH      = 90000;
  localparam int unsigned STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // RAM macro: write at the edge after mem_en, read data valid for the next edge
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk)
    if (bus.mem_en && bus.mem_we && bus.mem_addr < ADDR_W'(DEPTH))
      ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = (bus.mem_en && bus.mem_addr < ADDR_W'(DEPTH)) ?
                         ram[bus.mem_addr] : 24'h5A5A5A;

  int tests = 0;
  int fails = 0;

  // Reference model: golden memory updated in acceptance order
  logic [23:0] gold [int];
  int          starve = 0;
  logic        exp_en = 0, exp_we = 0, exp_err = 0;
  logic [16:0] exp_addr = '0;
  logic [23:0] exp_wdata = '0;
  logic        exp_crv = 0, exp_vrv = 0;
  logic [23:0] exp_crd = '0, exp_vrd = '0;
  logic        st1_valid = 0, st1_vid = 0;
  logic [23:0] st1_data = '0;
  logic        last_cstall = 0, last_vstall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] gold_rd(input int a);
    return gold.exists(a) ? gold[a] : 24'h0;
  endfunction

  // One clock cycle: check registered outputs, apply inputs, check stalls, advance model
  task automatic cyc(input logic r, input logic cr, input logic cwe, input logic [23:0] ca,
                     input logic [23:0] cwd, input logic vr, input logic [16:0] va);
    int   winner;
    logic cst, vst;
    @(negedge clk);
    check("mem_en", 32'(bus.mem_en), 32'(exp_en));
    check("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (exp_en) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    if (exp_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
    check("cpu_err", 32'(bus.cpu_err), 32'(exp_err));
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_crv));
    check("vid_rvalid", 32'(bus.vid_rvalid), 32'(exp_vrv));
    check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_crd));
    check("vid_rdata", 32'(bus.vid_rdata), 32'(exp_vrd));

    rst = r;
    bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
    bus.vid_req = vr; bus.vid_addr = va;
    #1;

    // winner: 0 none, 1 CPU, 2 VID
    if (r) winner = 0;
    else if (vr && starve == int'(STARVE_MAX)) winner = 2;
    else if (cr) winner = 1;
    else if (vr) winner = 2;
    else winner = 0;
    cst = !r && cr && winner != 1;
    vst = !r && vr && winner != 2;
    check("cpu_stall", 32'(bus.cpu_stall), 32'(cst));
    check("vid_stall", 32'(bus.vid_stall), 32'(vst));
    last_cstall = cst;
    last_vstall = vst;

    exp_crv = 0; exp_vrv = 0;
    exp_en = 0; exp_we = 0; exp_err = 0;
    if (r) begin
      exp_crd = '0; exp_vrd = '0;
      st1_valid = 0;
      starve = 0;
    end else begin
      if (st1_valid && !st1_vid) begin exp_crv = 1; exp_crd = st1_data; end
      if (st1_valid && st1_vid)  begin exp_vrv = 1; exp_vrd = st1_data; end
      st1_valid = 0;
      if (winner == 1) begin
        if (ca >= DEPTH) begin
          exp_err = 1;
          if (!cwe) begin st1_valid = 1; st1_vid = 0; st1_data = '0; end
        end else begin
          exp_en = 1; exp_we = cwe; exp_addr = ca[16:0]; exp_wdata = cwd;
          if (cwe) gold[int'(ca)] = cwd;
          else begin st1_valid = 1; st1_vid = 0; st1_data = gold_rd(int'(ca)); end
        end
      end else if (winner == 2) begin
        st1_valid = 1; st1_vid = 1;
        if (va >= DEPTH) st1_data = '0;
        else begin exp_en = 1; exp_addr = va; st1_data = gold_rd(int'(va)); end
      end
      if (!vr || winner == 2) starve = 0;
      else if (starve < int'(STARVE_MAX)) starve++;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    logic        c_r, c_we, v_r, r_r;
    logic [23:0] c_a, c_d;
    logic [16:0] v_a;
    c_r = 0; c_we = 0; v_r = 0; c_a = '0; c_d = '0; v_a = '0;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 0; bus.vid_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = '0;

    // Reset held with both requests high
    cyc(1, 1, 0, 24'd0, 24'd0, 1, 17'd2);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_vid_stall", 32'(bus.vid_stall), 32'd0);
    cyc(1, 1, 0, 24'd0, 24'd0, 1, 17'd2);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);

    // First cycle after release goes to the CPU; store then load
    cyc(0, 1, 1, 24'd1, 24'hABCDEF, 1, 17'd2);
    check("first_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("first_vid_stall", 32'(bus.vid_stall), 32'd1);
    cyc(0, 1, 0, 24'd1, 24'd0, 0, 17'd0);
    check("st_mem_we", 32'(bus.mem_we), 32'd1);
    check("st_mem_addr", 32'(bus.mem_addr), 32'd1);
    idle();
    check("ld_mem_we", 32'(bus.mem_we), 32'd0);
    idle();
    check("ld_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("ld_rdata", 32'(bus.cpu_rdata), 32'hABCDEF);

    // Seed addr 2 and exercise the last valid word
    cyc(0, 1, 1, 24'd2, 24'h123456, 0, 17'd0);
    cyc(0, 1, 1, 24'd89999, 24'h0FEDCB, 0, 17'd0);
    cyc(0, 1, 0, 24'd89999, 24'd0, 0, 17'd0);
    idle();
    idle();
    check("last_word_rdata", 32'(bus.cpu_rdata), 32'h0FEDCB);

    // Starvation: three VID stalls, forced grant on the fourth cycle
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 24'd1, 24'd0, 1, 17'd2);
      check("starve_vid_stall", 32'(bus.vid_stall), (k < 3) ? 32'd1 : 32'd0);
      check("starve_cpu_stall", 32'(bus.cpu_stall), (k == 3) ? 32'd1 : 32'd0);
    end
    cyc(0, 1, 0, 24'd1, 24'd0, 0, 17'd0);
    idle();
    check("starve_vid_rvalid", 32'(bus.vid_rvalid), 32'd1);
    check("starve_vid_rdata", 32'(bus.vid_rdata), 32'h123456);

    // Out-of-range CPU load, then out-of-range VID read
    cyc(0, 1, 0, 24'd90064, 24'd0, 0, 17'd0);
    idle();
    check("oor_cpu_err", 32'(bus.cpu_err), 32'd1);
    check("oor_mem_en", 32'(bus.mem_en), 32'd0);
    idle();
    check("oor_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("oor_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    cyc(0, 1, 0, 24'd90000, 24'd0, 0, 17'd0);
    cyc(0, 0, 0, 24'd0, 24'd0, 1, 17'd90001);
    check("oor_boundary_err", 32'(bus.cpu_err), 32'd1);
    idle();
    check("oor_vid_no_err", 32'(bus.cpu_err), 32'd0);
    idle();
    check("oor_vid_rvalid", 32'(bus.vid_rvalid), 32'd1);
    check("oor_vid_rdata", 32'(bus.vid_rdata), 32'd0);

    // Back-to-back alternating requesters
    cyc(0, 1, 1, 24'd5, 24'h55AA11, 0, 17'd0);
    cyc(0, 1, 1, 24'd6, 24'h66BB22, 0, 17'd0);
    cyc(0, 1, 0, 24'd5, 24'd0, 0, 17'd0);
    cyc(0, 0, 0, 24'd0, 24'd0, 1, 17'd6);
    check("b2b_addr0", 32'(bus.mem_addr), 32'd5);
    idle();
    check("b2b_addr1", 32'(bus.mem_addr), 32'd6);
    check("b2b_cpu_rdata", 32'(bus.cpu_rdata), 32'h55AA11);
    idle();
    check("b2b_vid_rdata", 32'(bus.vid_rdata), 32'h66BB22);
    check("b2b_cpu_quiet", 32'(bus.cpu_rvalid), 32'd0);

    // Store then same-address VID read on the next cycle sees new data
    cyc(0, 1, 1, 24'd7, 24'h777777, 0, 17'd0);
    cyc(0, 0, 0, 24'd0, 24'd0, 1, 17'd7);
    idle();
    idle();
    check("hazard_vid_rdata", 32'(bus.vid_rdata), 32'h777777);

    // Reset mid-flight with a partially built starvation count
    cyc(0, 1, 0, 24'd1, 24'd0, 1, 17'd2);
    cyc(0, 1, 0, 24'd5, 24'd0, 1, 17'd2);
    cyc(1, 1, 0, 24'd5, 24'd0, 1, 17'd2);
    cyc(0, 1, 0, 24'd5, 24'd0, 1, 17'd2);
    check("midrst_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 24'd5, 24'd0, 1, 17'd2);
      check("midrst_vid_stall", 32'(bus.vid_stall), (k < 2) ? 32'd1 : 32'd0);
    end
    idle();
    idle();

    // Randomized traffic; stalled requesters hold their request stable
    for (int i = 0; i < 3000; i++) begin
      if (!last_cstall) begin
        c_r  = $urandom_range(0, 99) < 60;
        c_we = 1'($urandom_range(0, 1));
        c_a  = ($urandom_range(0, 9) == 0) ? 24'($urandom_range(DEPTH, 24'hFFFFFF))
                                           : 24'($urandom_range(0, 15));
        c_d  = 24'($urandom);
      end
      if (!last_vstall) begin
        v_r = $urandom_range(0, 99) < 60;
        v_a = ($urandom_range(0, 9) == 0) ? 17'($urandom_range(DEPTH, 131071))
                                          : 17'($urandom_range(0, 15));
      end
      r_r = ($urandom_range(0, 199) == 0);
      cyc(r_r, c_r, c_we, c_a, c_d, v_r, v_a);
    end
    idle();
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data RAM (24-bit words, 17-bit address) between two requesters.
  - Requester 0: the pipeline memory stage (CPU). It can load and store.
  - Requester 1: the video/readout engine (VID). It only reads.
- Fixed CPU priority, with a starvation guard that forces a VID grant.
- Registered RAM command; read data routed back with a valid strobe.
- Sits between the memory stage / video engine and the RAM macro.

Parameters:
- DATA_W, 24, word width.
- ADDR_W, 17, RAM address width.
- DEPTH, 90000, number of valid words; addresses >= DEPTH are out of range.
- STARVE_MAX, 3, consecutive VID stall cycles before VID is forced to win.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  24  CPU word address (ALU result)
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  request not accepted this cycle (combinational)
- cpu_rvalid  out  1  load data valid
- cpu_rdata  out  DATA_W  load data
- cpu_err  out  1  out-of-range access pulse
- vid_req  in  1  VID read request
- vid_addr  in  ADDR_W  VID word address
- vid_stall  out  1  request not accepted this cycle (combinational)
- vid_rvalid  out  1  read data valid
- vid_rdata  out  DATA_W  read data
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en

Behaviour:
- Reset values: all outputs 0; starvation counter 0; return pipeline cleared.
- Arbitration, evaluated each cycle N from current inputs:
  - force_vid = vid_req && (starve_cnt == STARVE_MAX).
  - If force_vid: VID wins.
  - Else if cpu_req: CPU wins.
  - Else if vid_req: VID wins.
  - The loser's stall = its req. A requester with req=0 never stalls.
- Acceptance: a request is accepted when req && !stall. The requester must hold address/data/we stable while stalled.
- Command issue: an accepted in-range request is driven on mem_* at edge N+1 (mem_en=1 for one cycle). With no accepted request, mem_en=0 and mem_we=0.
- Out-of-range CPU access (cpu_addr >= DEPTH, including any upper bits set):
  - Still arbitrates and is accepted normally.
  - mem_en stays 0, so no RAM access occurs.
  - cpu_err pulses at N+1.
  - A load returns cpu_rdata=0 with cpu_rvalid at N+2.
  - A store is dropped.
- VID address out of range (vid_addr >= DEPTH):
  - No RAM access.
  - vid_rdata=0, with vid_rvalid at N+2.
  - No error flag.
- Read return:
  - An owner tag is pipelined two stages alongside the access.
  - At N+2 the matching rvalid pulses for one cycle and its rdata is loaded from mem_rdata (or 0 for out of range).
  - rdata holds its value until the next rvalid for that requester.
  - Stores produce no rvalid.
- Load-to-use: throughput is one access per cycle; latency is 2 cycles from acceptance to rvalid.
- Starvation counter:
  - Increments on each cycle with vid_req && vid_stall, saturating at STARVE_MAX.
  - Clears to 0 on VID acceptance or when vid_req=0.
- Same-address hazard: a CPU store at N followed by a VID read of the same address at N+1 returns the new data. This follows from command order; no bypass logic.
- Reset mid-operation: in-flight rvalids are squashed (not delivered), the counter clears, and mem_en drops at the reset edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both requests high → all outputs 0, mem_en=0; after release, CPU granted the first cycle.
- CPU store/load: store 24'hABCDEF to addr 1, then load addr 1 → mem_we=1, mem_addr=1 at N+1; cpu_rvalid at load N+2 with cpu_rdata=24'hABCDEF; no stalls.
- Contention and starvation (STARVE_MAX=3): cpu_req held high with vid_req=1 at addr 2 →
  - vid_stall for 3 cycles, then VID accepted on the 4th.
  - cpu_stall=1 on that cycle only.
  - vid_rvalid 2 cycles later.
- Out of range: CPU load at addr 24'd90064 → cpu_err pulse at N+1, mem_en=0, cpu_rvalid=1 with cpu_rdata=0 at N+2. VID read at 17'd90001 → vid_rdata=0, vid_rvalid=1 at N+2.
- Back-to-back alternating: CPU load addr 5 at N, VID read addr 6 at N+1 → mem_addr sequence 5, 6; cpu_rvalid at N+2 and vid_rvalid at N+3 with the correct words, no cross-routing.
- Reset mid-flight: accept a CPU load, assert rst at N+1 → no cpu_rvalid at N+2; starvation counter reads 0.
